// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular exponentiation controller.
//
// Contents:
//   DEFAULT_DATAWIDTH : default operand/modulus/exponent width in bits.
//   state_t           : controller FSM state encoding.
package modexp_pkg;

  localparam int DEFAULT_DATAWIDTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    MAP,
    SQUARE,
    MULTIPLY,
    UNMAP,
    DONE
  } state_t;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right binary modular exponentiation controller (C = M^E mod N).
// Arithmetic is done in the Montgomery domain by an external monpro unit.
// That unit is instantiated next to this block by the integrating level.
//
// Parameters:
//   DATAWIDTH : operand, modulus and exponent width (R = 2^DATAWIDTH).
//
// Ports:
//   clk, rst                      : clock and asynchronous active-high reset.
//   in_valid / in_ready           : job handshake.
//   i_M, i_E, i_N                 : message, exponent and odd modulus.
//   i_RmodN, i_R2modN             : R mod N and R^2 mod N.
//   out_valid / out_ready, o_C    : result handshake and result.
//   mp_start                      : one-cycle start pulse to monpro.
//   mp_ready                      : monpro idle flag.
//   mp_valid                      : monpro result strobe.
//   mp_A, mp_B, mp_N              : monpro operands.
//   mp_U                          : monpro result.
//
// Build option:
//   MODEXP_SKIP_LEADING_ZEROS_EN - when defined, exponent bits above the
//   most significant set bit are skipped without issuing any MonPro.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] i_M,
  input  logic [DATAWIDTH-1:0] i_E,
  input  logic [DATAWIDTH-1:0] i_N,
  input  logic [DATAWIDTH-1:0] i_RmodN,
  input  logic [DATAWIDTH-1:0] i_R2modN,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] o_C,
  output logic                 mp_start,
  input  logic                 mp_ready,
  input  logic                 mp_valid,
  output logic [DATAWIDTH-1:0] mp_A,
  output logic [DATAWIDTH-1:0] mp_B,
  output logic [DATAWIDTH-1:0] mp_N,
  input  logic [DATAWIDTH-1:0] mp_U
);

  localparam int IW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(DATAWIDTH - 1);

  state_t               state;
  logic [DATAWIDTH-1:0] m_reg, e_reg, n_reg, rmodn_reg, r2modn_reg;
  logic [DATAWIDTH-1:0] xbar, acc;
  logic [IW-1:0]        idx;
  logic                 op_busy;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic                 leading;
`endif

  logic                 need_op;
  logic                 op_done;
  logic [DATAWIDTH-1:0] op_a, op_b;

  assign in_ready = (state == IDLE) && !rst;
  assign mp_N     = n_reg;

  // A result is only accepted for an operation this job actually issued.
  // Strobes arriving with nothing outstanding (e.g. left over from a job
  // abandoned by reset) are dropped.
  assign op_done = op_busy && mp_valid && !mp_start;

  // Operand selection for the MonPro the current state needs.
  always_comb begin
    need_op = 1'b0;
    op_a    = '0;
    op_b    = '0;
    case (state)
      MAP: begin
        need_op = 1'b1;
        op_a    = m_reg;
        op_b    = r2modn_reg;
      end
      SQUARE: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        need_op = !leading;
`else
        need_op = 1'b1;
`endif
        op_a    = acc;
        op_b    = acc;
      end
      MULTIPLY: begin
        need_op = 1'b1;
        op_a    = acc;
        op_b    = xbar;
      end
      UNMAP: begin
        need_op = 1'b1;
        op_a    = acc;
        op_b    = DATAWIDTH'(1);
      end
      default: begin
        need_op = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      m_reg      <= '0;
      e_reg      <= '0;
      n_reg      <= '0;
      rmodn_reg  <= '0;
      r2modn_reg <= '0;
      xbar       <= '0;
      acc        <= '0;
      idx        <= '0;
      op_busy    <= 1'b0;
      mp_start   <= 1'b0;
      mp_A       <= '0;
      mp_B       <= '0;
      o_C        <= '0;
      out_valid  <= 1'b0;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      leading    <= 1'b0;
`endif
    end else begin
      mp_start <= 1'b0;

      // Issue at most one MonPro at a time; operands stay put until the
      // next issue, so they are stable for the whole operation.
      if (need_op && !op_busy && mp_ready) begin
        mp_A     <= op_a;
        mp_B     <= op_b;
        mp_start <= 1'b1;
        op_busy  <= 1'b1;
      end

      if (op_done) begin
        op_busy <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg      <= i_M;
            e_reg      <= i_E;
            n_reg      <= i_N;
            rmodn_reg  <= i_RmodN;
            r2modn_reg <= i_R2modN;
            state      <= MAP;
          end
        end

        MAP: begin
          if (op_done) begin
            xbar <= mp_U;
            acc  <= rmodn_reg;
            idx  <= TOP_IDX;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            leading <= 1'b1;
            state   <= (e_reg == '0) ? UNMAP : SQUARE;
`else
            state <= SQUARE;
`endif
          end
        end

        SQUARE: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          // While still above the first set bit acc equals RmodN (the
          // Montgomery form of 1), so squaring it is pointless. At the
          // first set bit go straight to the multiply. A set bit must exist
          // below, so the index cannot run past 0 here.
          if (leading) begin
            if (e_reg[idx]) begin
              leading <= 1'b0;
              state   <= MULTIPLY;
            end else begin
              idx <= idx - IW'(1);
            end
          end else
`endif
          if (op_done) begin
            acc <= mp_U;
            if (e_reg[idx]) begin
              state <= MULTIPLY;
            end else if (idx == '0) begin
              state <= UNMAP;
            end else begin
              idx <= idx - IW'(1);
            end
          end
        end

        MULTIPLY: begin
          if (op_done) begin
            acc <= mp_U;
            if (idx == '0) begin
              state <= UNMAP;
            end else begin
              idx   <= idx - IW'(1);
              state <= SQUARE;
            end
          end
        end

        UNMAP: begin
          if (op_done) begin
            o_C       <= mp_U;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed testbench for modexp_ctrl at DATAWIDTH = 8 with N = 0x0B.
// A behavioural monpro model sits beside the DUT. It has a 3-cycle latency
// and an optional idle gap before each operation.
// Build option mirrored from the DUT: MODEXP_SKIP_LEADING_ZEROS_EN.
module tb_modexp_ctrl;

  localparam int DW = 8;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] i_M = '0, i_E = '0, i_N = '0, i_RmodN = '0, i_R2modN = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] o_C;
  logic          mp_start;
  logic          mp_ready;
  logic          mp_valid = 1'b0;
  logic [DW-1:0] mp_A, mp_B, mp_N;
  logic [DW-1:0] mp_U = '0;

  int checks = 0;
  int errors = 0;

  // monpro model state
  logic          m_busy = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] m_res = '0;
  int            gap = 0;
  int            ready_delay = 0;
  int            start_count = 0;
  logic [DW-1:0] cur_n = 8'h0B;
  int            start_base = 0;

  modexp_ctrl #(.DATAWIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .i_M      (i_M),
    .i_E      (i_E),
    .i_N      (i_N),
    .i_RmodN  (i_RmodN),
    .i_R2modN (i_R2modN),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o_C      (o_C),
    .mp_start (mp_start),
    .mp_ready (mp_ready),
    .mp_valid (mp_valid),
    .mp_A     (mp_A),
    .mp_B     (mp_B),
    .mp_N     (mp_N),
    .mp_U     (mp_U)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // MonPro(a, b) = a*b*R^-1 mod 11, and R^-1 mod 11 = 4 (256*4 = 93*11 + 1).
  function automatic logic [DW-1:0] mont(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int p;
    p = (int'(a) * int'(b) * 4) % 11;
    return p[DW-1:0];
  endfunction

  assign mp_ready = !m_busy && !mp_valid && (gap == 0);

  // monpro model; it is not reset by rst, so an abandoned job's result still
  // arrives later.
  always @(posedge clk) begin
    mp_valid <= 1'b0;
    if (gap > 0) gap <= gap - 1;
    if (in_valid && in_ready) gap <= ready_delay;
    if (m_busy) begin
      if (m_cnt == 1) begin
        mp_valid <= 1'b1;
        mp_U     <= m_res;
        m_busy   <= 1'b0;
        gap      <= ready_delay;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    if (mp_start) begin
      checkOutput("start_when_ready", {31'b0, mp_ready}, 32'd1);
      checkOutput("mp_N_latched", {24'b0, mp_N}, {24'b0, cur_n});
      start_count <= start_count + 1;
      m_busy      <= 1'b1;
      m_cnt       <= 3;
      m_res       <= mont(mp_A, mp_B);
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] m, input logic [DW-1:0] e);
    @(negedge clk);
    i_M      = m;
    i_E      = e;
    i_N      = cur_n;
    i_RmodN  = 8'h03;
    i_R2modN = 8'h09;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    checkOutput("in_ready_for_job", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    start_base = start_count;
  endtask

  task automatic waitOutValid(input string tag);
    for (int i = 0; i < 3000 && !out_valid; i++) @(negedge clk);
    checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic runJob(input string tag, input logic [DW-1:0] m, input logic [DW-1:0] e,
                        input logic [DW-1:0] expc, input int exps);
    applyStimulus(m, e);
    waitOutValid(tag);
    checkOutput({tag, "_C"}, {24'b0, o_C}, {24'b0, expc});
    checkOutput({tag, "_starts"}, start_count - start_base, exps);
    @(negedge clk);
    checkOutput({tag, "_back_idle"}, {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    bit stable;
    $display("[TB] modexp_ctrl directed test, skip_leading_zeros=%0d", SKIP);

    // reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_mp_start", {31'b0, mp_start}, 32'd0);
    checkOutput("rst_o_C", {24'b0, o_C}, 32'd0);
    checkOutput("rst_mp_ops", {8'b0, mp_A, mp_B, mp_N}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // main function
    runJob("m04_e0d", 8'h04, 8'h0D, 8'h09, SKIP ? 8 : 13);
    runJob("m07_e00", 8'h07, 8'h00, 8'h01, SKIP ? 2 : 10);
    runJob("m0f_e01", 8'h0F, 8'h01, 8'h04, SKIP ? 3 : 11);
    runJob("m00_e05", 8'h00, 8'h05, 8'h00, SKIP ? 6 : 12);

    // output back-pressure
    out_ready = 1'b0;
    applyStimulus(8'h04, 8'h0D);
    waitOutValid("stall");
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && o_C === 8'h09 && in_ready === 1'b0)) stable = 1'b0;
    end
    checkOutput("stall_stable", {31'b0, stable}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release", {30'b0, out_valid, in_ready}, 32'b01);

    // reset while the first SQUARE MonPro is in flight
    applyStimulus(8'h04, 8'h0D);
    for (int i = 0; i < 200 && !((start_count - start_base) == 2 && m_busy); i++) @(negedge clk);
    checkOutput("rst_mid_reached", start_count - start_base, 2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_outs", {29'b0, in_ready, out_valid, mp_start}, 32'd0);
    checkOutput("rst_mid_o_C", {24'b0, o_C}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!(in_ready === 1'b1 && out_valid === 1'b0 && mp_start === 1'b0)) stable = 1'b0;
      @(negedge clk);
    end
    checkOutput("stale_ignored", {31'b0, stable}, 32'd1);
    runJob("after_rst", 8'h04, 8'h0D, 8'h09, SKIP ? 8 : 13);

    // monpro slow to become ready
    ready_delay = 10;
    runJob("slow_m04_e0d", 8'h04, 8'h0D, 8'h09, SKIP ? 8 : 13);
    runJob("slow_m07_e00", 8'h07, 8'h00, 8'h01, SKIP ? 2 : 10);
    ready_delay = 0;

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
